// File: rtl/rx_data_sampler_if.sv
// Bundle between the UART receive FSM (master) and the oversampling data sampler (slave).
interface rx_data_sampler_if #(
    parameter int PRESC_WD   = 6,
    parameter int BIT_CNT_WD = 4
);
    logic                  RX_IN;
    logic [PRESC_WD-1:0]   Prescale;
    logic                  enable;
    logic                  dat_samp_en;
    logic [PRESC_WD-1:0]   edge_cnt;
    logic [BIT_CNT_WD-1:0] bit_cnt;
    logic                  sampled_bit;
    logic                  samp_valid;

    modport master (
        output RX_IN, Prescale, enable, dat_samp_en,
        input  edge_cnt, bit_cnt, sampled_bit, samp_valid
    );

    modport slave (
        input  RX_IN, Prescale, enable, dat_samp_en,
        output edge_cnt, bit_cnt, sampled_bit, samp_valid
    );
endinterface

// File: rtl/rx_data_sampler.sv
// UART RX oversampling stage: per-bit edge/bit counters and a three-sample majority
// vote centred on the bit midpoint.
module rx_data_sampler #(
    parameter int PRESC_WD   = 6,
    parameter int BIT_CNT_WD = 4
) (
    input  logic CLK,
    input  logic RST,
    rx_data_sampler_if.slave bus
);

    logic [PRESC_WD-1:0]   p_eff_q, p_eff_d;
    logic [PRESC_WD-1:0]   edge_q, edge_d;
    logic [BIT_CNT_WD-1:0] bit_q, bit_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic                  sb_q, sb_d;
    logic                  sv_q, sv_d;
    logic [PRESC_WD-1:0]   half;

    // Unsupported ratios fall back to 8 so the counters always have a sane period.
    function automatic logic [PRESC_WD-1:0] legal_presc(input logic [PRESC_WD-1:0] p);
        if (p == PRESC_WD'(8) || p == PRESC_WD'(16) || p == PRESC_WD'(32))
            return p;
        return PRESC_WD'(8);
    endfunction

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign half = p_eff_q >> 1;

    always_comb begin
        p_eff_d = p_eff_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        sb_d    = sb_q;
        sv_d    = 1'b0;

        if (!bus.enable) begin
            p_eff_d = legal_presc(bus.Prescale);
            edge_d  = '0;
            bit_d   = '0;
        end else if (edge_q == p_eff_q - 1'b1) begin
            edge_d = '0;
            bit_d  = bit_q + 1'b1;
        end else begin
            edge_d = edge_q + 1'b1;
        end

        // Samples at M-1, M, M+1; the vote lands on the M+1 edge.
        if (bus.dat_samp_en) begin
            if (edge_q == half - 1'b1)
                s0_d = bus.RX_IN;
            if (edge_q == half)
                s1_d = bus.RX_IN;
            if (edge_q == half + 1'b1) begin
                sb_d = majority(s0_q, s1_q, bus.RX_IN);
                sv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_eff_q <= PRESC_WD'(8);
            edge_q  <= '0;
            bit_q   <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            sb_q    <= 1'b1;
            sv_q    <= 1'b0;
        end else begin
            p_eff_q <= p_eff_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            sb_q    <= sb_d;
            sv_q    <= sv_d;
        end
    end

    assign bus.edge_cnt    = edge_q;
    assign bus.bit_cnt     = bit_q;
    assign bus.sampled_bit = sb_q;
    assign bus.samp_valid  = sv_q;

endmodule

// File: tb/tb_rx_data_sampler.sv
// Bench for rx_data_sampler: per-cycle reference model, vote table, directed frames,
// reset/enable corners and a randomized run.
module tb_rx_data_sampler;

    localparam int PW = 6;
    localparam int BW = 4;

    logic CLK;
    logic RST;

    rx_data_sampler_if #(.PRESC_WD(PW), .BIT_CNT_WD(BW)) bus ();

    rx_data_sampler #(.PRESC_WD(PW), .BIT_CNT_WD(BW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: k = clocks counted since enable rose; counters derive from k.
    int k;
    int peff;
    bit m_s0, m_s1, m_sb, m_sv;

    function automatic int legal(input int p);
        return (p == 8 || p == 16 || p == 32) ? p : 8;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0; peff = 8; m_s0 = 1; m_s1 = 1; m_sb = 1; m_sv = 0;
    endtask

    task automatic model_edge();
        int e;
        int m;
        e = k % peff;
        m = peff / 2;
        m_sv = 0;
        if (bus.dat_samp_en) begin
            if (e == m - 1) m_s0 = bus.RX_IN;
            if (e == m)     m_s1 = bus.RX_IN;
            if (e == m + 1) begin
                m_sb = ((int'(m_s0) + int'(m_s1) + int'(bus.RX_IN)) >= 2);
                m_sv = 1;
            end
        end
        if (bus.enable) k = k + 1;
        else begin
            k = 0;
            peff = legal(int'(bus.Prescale));
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check("model edge_cnt",    int'(bus.edge_cnt),    k % peff);
        check("model bit_cnt",     int'(bus.bit_cnt),     (k / peff) % 16);
        check("model sampled_bit", int'(bus.sampled_bit), int'(m_sb));
        check("model samp_valid",  int'(bus.samp_valid),  int'(m_sv));
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #2;
        model_reset();
        check("rst edge_cnt",    int'(bus.edge_cnt),    0);
        check("rst bit_cnt",     int'(bus.bit_cnt),     0);
        check("rst sampled_bit", int'(bus.sampled_bit), 1);
        check("rst samp_valid",  int'(bus.samp_valid),  0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic idle(input int presc, input int n);
        bus.enable = 1'b0; bus.dat_samp_en = 1'b0; bus.RX_IN = 1'b1;
        bus.Prescale = PW'(presc);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        int presc;
        int peff;
        int lo_start;
        int lo_len;
        bit exp_sb;
    } vec_t;

    vec_t vt[10];

    initial begin
        int pulses, pulse_edge, max_edge, exp_b, bitv;
        int plist[6];

        vt[0] = '{8,  8,  3,  2, 1'b0};
        vt[1] = '{16, 16, 8,  1, 1'b1};
        vt[2] = '{16, 16, 7,  2, 1'b0};
        vt[3] = '{32, 32, 17, 1, 1'b1};
        vt[4] = '{32, 32, 15, 3, 1'b0};
        vt[5] = '{5,  8,  4,  1, 1'b1};
        vt[6] = '{5,  8,  3,  3, 1'b0};
        vt[7] = '{0,  8,  5,  1, 1'b1};
        vt[8] = '{63, 8,  0,  8, 1'b0};
        vt[9] = '{16, 16, 0,  7, 1'b1};
        plist = '{8, 16, 32, 5, 0, 63};

        RST = 1'b1;
        bus.RX_IN = 1'b1; bus.Prescale = PW'(8); bus.enable = 1'b0; bus.dat_samp_en = 1'b0;
        #3;
        do_reset();

        // One-bit vote table: low window relative to edge_cnt, expected voted value.
        foreach (vt[i]) begin
            idle(vt[i].presc, 2);
            bus.enable = 1'b1; bus.dat_samp_en = 1'b1;
            pulses = 0; pulse_edge = -1; max_edge = 0;
            for (int c = 0; c < vt[i].peff; c++) begin
                bus.RX_IN = (c >= vt[i].lo_start && c < vt[i].lo_start + vt[i].lo_len) ? 1'b0 : 1'b1;
                step();
                if (bus.samp_valid) begin pulses++; pulse_edge = int'(bus.edge_cnt); end
                if (int'(bus.edge_cnt) > max_edge) max_edge = int'(bus.edge_cnt);
            end
            check($sformatf("tbl%0d sampled_bit", i), int'(bus.sampled_bit), int'(vt[i].exp_sb));
            check($sformatf("tbl%0d pulses", i), pulses, 1);
            check($sformatf("tbl%0d pulse_edge", i), pulse_edge, vt[i].peff / 2 + 2);
            check($sformatf("tbl%0d wrap", i), max_edge, vt[i].peff - 1);
            check($sformatf("tbl%0d bit_cnt", i), int'(bus.bit_cnt), 1);
        end

        // 0x55 frame at Prescale 8: start, data LSB-first, stop.
        idle(8, 2);
        bus.enable = 1'b1; bus.dat_samp_en = 1'b1;
        pulses = 0;
        for (int b = 0; b < 10; b++) begin
            exp_b = (b == 0) ? 0 : (b == 9) ? 1 : ((8'h55 >> (b - 1)) & 1);
            bus.RX_IN = exp_b[0];
            for (int c = 0; c < 8; c++) begin
                step();
                if (bus.samp_valid) begin
                    pulses++;
                    check("frame bit value", int'(bus.sampled_bit), exp_b);
                    check("frame bit_cnt", int'(bus.bit_cnt), b);
                    check("frame pulse edge", int'(bus.edge_cnt), 6);
                end
            end
        end
        check("frame pulses", pulses, 10);

        // Prescale 32 for 64 clocks.
        idle(32, 2);
        bus.enable = 1'b1;
        for (int c = 0; c < 64; c++) step();
        check("p32 edge after 64", int'(bus.edge_cnt), 0);
        check("p32 bit after 64", int'(bus.bit_cnt), 2);

        // Prescale change mid-frame is ignored until enable drops.
        idle(8, 2);
        bus.enable = 1'b1;
        for (int c = 0; c < 3; c++) step();
        bus.Prescale = PW'(16);
        max_edge = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (int'(bus.edge_cnt) > max_edge) max_edge = int'(bus.edge_cnt);
        end
        check("frozen prescale wrap", max_edge, 7);
        bus.enable = 1'b0;
        step();
        bus.enable = 1'b1;
        max_edge = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (int'(bus.edge_cnt) > max_edge) max_edge = int'(bus.edge_cnt);
        end
        check("reloaded prescale wrap", max_edge, 15);

        // Enable drop at bit 3 / edge 4, re-raise one clock later.
        idle(8, 2);
        bus.enable = 1'b1; bus.dat_samp_en = 1'b1; bus.RX_IN = 1'b0;
        for (int c = 0; c < 28; c++) step();
        check("pre-drop edge", int'(bus.edge_cnt), 4);
        check("pre-drop bit", int'(bus.bit_cnt), 3);
        check("pre-drop sampled", int'(bus.sampled_bit), 0);
        bus.enable = 1'b0; bus.dat_samp_en = 1'b0;
        step();
        check("drop edge", int'(bus.edge_cnt), 0);
        check("drop bit", int'(bus.bit_cnt), 0);
        bus.enable = 1'b1; bus.dat_samp_en = 1'b1; bus.RX_IN = 1'b1;
        step();
        check("restart edge", int'(bus.edge_cnt), 1);
        check("restart bit", int'(bus.bit_cnt), 0);
        check("restart sampled held", int'(bus.sampled_bit), 0);
        for (int c = 0; c < 3; c++) step();
        do_reset();

        // Randomized run against the model.
        bus.enable = 1'b0; bus.dat_samp_en = 1'b0; bus.RX_IN = 1'b1;
        bus.Prescale = PW'(8);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) bus.Prescale = PW'(plist[$urandom_range(0, 5)]);
            if ($urandom_range(0, 59) == 0) bus.enable = ~bus.enable;
            bus.dat_samp_en = bus.enable & ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) bus.RX_IN = ~bus.RX_IN;
            if ($urandom_range(0, 999) == 0) begin
                bitv = 0;
                do_reset();
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
